// File: rtl/axi4_stream_pkg.sv
// axi4_stream_pkg: shared definitions for the stream multiplier link (engine and
// master-side wrappers).
// Contents: state_t FSM encoding, nbeats() beats-per-transfer helper.
package axi4_stream_pkg;

  typedef enum logic [1:0] {
    RX    = 2'd0,
    MUL   = 2'd1,
    TX    = 2'd2,
    DRAIN = 2'd3
  } state_t;

  // Beats needed to carry one 2*sz-bit transfer over a dsz-bit stream.
  function automatic int nbeats(input int sz, input int dsz);
    return (2 * sz) / dsz;
  endfunction

endpackage

// File: rtl/axi4_stream_mul_engine_if.sv
// axi4_stream_mul_engine_if: request (s_*) and result (m_*) stream bundle of the
// multiply engine.
// Modports: slave = engine side, master = requester/consumer side.
interface axi4_stream_mul_engine_if #(
  parameter int DSZ   = 8,
  parameter int TID_W = 2
);
  logic [DSZ-1:0]   s_tdata;
  logic             s_tvalid;
  logic             s_tready;
  logic             s_tlast;
  logic [TID_W-1:0] s_tid;
  logic [DSZ-1:0]   m_tdata;
  logic             m_tvalid;
  logic             m_tready;
  logic             m_tlast;
  logic [TID_W-1:0] m_tid;

  modport slave (
    input  s_tdata, s_tvalid, s_tlast, s_tid, m_tready,
    output s_tready, m_tdata, m_tvalid, m_tlast, m_tid
  );

  modport master (
    output s_tdata, s_tvalid, s_tlast, s_tid, m_tready,
    input  s_tready, m_tdata, m_tvalid, m_tlast, m_tid
  );
endinterface

// File: rtl/axi4_stream_beat_serializer.sv
// axi4_stream_beat_serializer: holds a W-bit word plus tag and emits it LSB beat first
// as W/DSZ stream beats; outputs are register-driven and stay stable while stalled.
// Ports: clk, _rst (sync, active-high), load/word/tid_in, tdata/tvalid/tready/tlast/tid, done.
module axi4_stream_beat_serializer #(
  parameter int W     = 64,
  parameter int DSZ   = 8,
  parameter int TID_W = 2
) (
  input  logic             clk,
  input  logic             _rst,
  input  logic             load,
  input  logic [W-1:0]     word,
  input  logic [TID_W-1:0] tid_in,
  output logic [DSZ-1:0]   tdata,
  output logic             tvalid,
  input  logic             tready,
  output logic             tlast,
  output logic [TID_W-1:0] tid,
  output logic             done
);
  localparam int NB = W / DSZ;
  localparam int IW = $clog2(NB);
  localparam logic [IW-1:0] LAST = IW'(NB - 1);

  logic [NB-1:0][DSZ-1:0] word_q;
  logic [TID_W-1:0]       tid_q;
  logic [IW-1:0]          j;
  logic                   vld;
  logic                   hs;

  assign hs   = vld && tready;
  assign done = hs && (j == LAST);

  always_ff @(posedge clk) begin
    if (_rst) begin
      word_q <= '0;
      tid_q  <= '0;
      j      <= '0;
      vld    <= 1'b0;
    end else if (load) begin
      word_q <= word;
      tid_q  <= tid_in;
      j      <= '0;
      vld    <= 1'b1;
    end else if (hs) begin
      if (j == LAST) begin
        vld <= 1'b0;
        j   <= '0;
      end else begin
        j <= j + 1'b1;
      end
    end
  end

  assign tdata  = word_q[j];
  assign tvalid = vld;
  assign tlast  = vld && (j == LAST);
  assign tid    = tid_q;
endmodule

// File: rtl/axi4_stream_mul_engine.sv
// axi4_stream_mul_engine: collects operand A then B (LSB beat first) from a DSZ-bit
// stream, forms the full 2*SZ-bit unsigned product and streams it back tagged with tid.
// Ports: clk, _rst (sync, active-high), bus (slave: s_* request, m_* result), busy,
//        err (length-error pulse), done_cnt (wrapping). Macro: AXIS_LEN_CHECK_EN.
module axi4_stream_mul_engine
  import axi4_stream_pkg::*;
#(
  parameter int SZ    = 32,
  parameter int DSZ   = 8,
  parameter int TID_W = 2,
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    _rst,
  axi4_stream_mul_engine_if.slave bus,
  output logic                    busy,
  output logic                    err,
  output logic [CNT_W-1:0]        done_cnt
);
  localparam int NB = nbeats(SZ, DSZ);
  localparam int IW = $clog2(NB);
  localparam logic [IW-1:0] LAST = IW'(NB - 1);

  generate
    if (SZ % DSZ != 0) begin : g_bad_width
      $error("axi4_stream_mul_engine: SZ must be a multiple of DSZ");
    end
  endgenerate

  state_t                 state, state_nxt;
  logic [IW-1:0]          idx, idx_nxt;
  logic [NB-1:0][DSZ-1:0] ops;      // beat i of the request lands in slot i: A low half, B high
  logic [2*SZ-1:0]        ops_flat;
  logic [2*SZ-1:0]        product;
  logic [TID_W-1:0]       tid_q;
  logic                   s_ready, beat_wr, load, done, err_nxt;

  assign ops_flat = ops;
  assign product  = {{SZ{1'b0}}, ops_flat[SZ-1:0]} * {{SZ{1'b0}}, ops_flat[2*SZ-1:SZ]};

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    err_nxt   = 1'b0;
    beat_wr   = 1'b0;
    load      = 1'b0;
    s_ready   = 1'b0;
    case (state)
      RX: begin
        s_ready = 1'b1;
        if (bus.s_tvalid) begin
`ifdef AXIS_LEN_CHECK_EN
          if (bus.s_tlast && (idx != LAST)) begin
            // short packet: throw away what was collected
            err_nxt = 1'b1;
            idx_nxt = '0;
          end else if (!bus.s_tlast && (idx == LAST)) begin
            // long packet: swallow the remainder up to its tlast
            err_nxt   = 1'b1;
            idx_nxt   = '0;
            state_nxt = DRAIN;
          end else
`endif
          begin
            beat_wr = 1'b1;
            if (idx == LAST) begin
              idx_nxt   = '0;
              state_nxt = MUL;
            end else begin
              idx_nxt = idx + 1'b1;
            end
          end
        end
      end
      MUL: begin
        load      = 1'b1;
        state_nxt = TX;
      end
      TX: begin
        if (done) state_nxt = RX;
      end
`ifdef AXIS_LEN_CHECK_EN
      DRAIN: begin
        s_ready = 1'b1;
        if (bus.s_tvalid && bus.s_tlast) state_nxt = RX;
      end
`endif
      default: state_nxt = RX;
    endcase
  end

  always_ff @(posedge clk) begin
    if (_rst) begin
      state    <= RX;
      idx      <= '0;
      ops      <= '0;
      tid_q    <= '0;
      err      <= 1'b0;
      done_cnt <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      err   <= err_nxt;
      if (beat_wr) begin
        ops[idx] <= bus.s_tdata;
        if (idx == '0) tid_q <= bus.s_tid;
      end
      if (done) done_cnt <= done_cnt + 1'b1;
    end
  end

`ifndef AXIS_LEN_CHECK_EN
  // s_tlast carries no meaning when lengths are not checked
  logic unused_tlast;
  assign unused_tlast = bus.s_tlast;
`endif

  assign bus.s_tready = s_ready && !_rst;
  assign busy         = !((state == RX) && (idx == '0));

  axi4_stream_beat_serializer #(
    .W     (2 * SZ),
    .DSZ   (DSZ),
    .TID_W (TID_W)
  ) u_ser (
    .clk    (clk),
    ._rst   (_rst),
    .load   (load),
    .word   (product),
    .tid_in (tid_q),
    .tdata  (bus.m_tdata),
    .tvalid (bus.m_tvalid),
    .tready (bus.m_tready),
    .tlast  (bus.m_tlast),
    .tid    (bus.m_tid),
    .done   (done)
  );
endmodule
